// File: rtl/vga_scanout.sv
// VGA 640x480@60 scanout: pixel-enable timing, 2x2 replicated framebuffer reads, aligned rgb/sync outputs.
// Optional VGA_SCANOUT_TEST_PATTERN_EN adds pattern_sel, which replaces rdata with 8 colour bars.
module vga_scanout #(
  parameter int DATA_WIDTH  = 12,
  parameter int ADDR_WIDTH  = 17,
  parameter int CLK_DIV     = 4,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int FB_WIDTH    = 320,
  parameter int SCALE_SHIFT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  input  logic                  pattern_sel,
`endif
  output logic [ADDR_WIDTH-1:0] araddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0]         DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0]         H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]         H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0]         HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]         HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0]         V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]         V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0]         VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]         VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [ADDR_WIDTH-1:0] FB_W     = ADDR_WIDTH'(FB_WIDTH);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          tick;

  assign tick = en && (div_q == DIV_LAST);

  // Dropping en restarts the raster at pixel (0,0) on the next clock.
  always_comb begin
    div_d  = div_q;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (!en) begin
      div_d  = '0;
      hcnt_d = '0;
      vcnt_d = '0;
    end else begin
      div_d = tick ? '0 : div_q + DW'(1);
      if (tick) begin
        if (hcnt_q == H_LAST) begin
          hcnt_d = '0;
          vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  logic active, hs_act, vs_act;

  assign active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign hs_act = (hcnt_q >= HS_START) && (hcnt_q <= HS_END);
  assign vs_act = (vcnt_q >= VS_START) && (vcnt_q <= VS_END);

  // Framebuffer address: each stored pixel covers a 2^SCALE_SHIFT square on screen.
  logic [ADDR_WIDTH-1:0] row_w, col_w, addr_w;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;

  assign row_w  = ADDR_WIDTH'(vcnt_q >> SCALE_SHIFT);
  assign col_w  = ADDR_WIDTH'(hcnt_q >> SCALE_SHIFT);
  assign addr_w = row_w * FB_W + col_w;

  always_comb begin
    araddr_d = '0;
    if (en && active) araddr_d = addr_w;
  end

  always_ff @(posedge clk) begin
    if (rst) araddr_q <= '0;
    else     araddr_q <= araddr_d;
  end

  assign araddr = araddr_q;

  logic [11:0] colour;

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0]  bar;
  logic [2:0]  bar_rgb;
  logic [11:0] bar_colour;

  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++)
      if (hcnt_q >= HW'(k * BAR_W)) bar = 3'(k);
    case (bar)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
    bar_colour = {{4{bar_rgb[2]}}, {4{bar_rgb[1]}}, {4{bar_rgb[0]}}};
  end

  assign colour = pattern_sel ? bar_colour : rdata[11:0];
`else
  assign colour = rdata[11:0];
`endif

  // rdata for the current pixel has settled by the tick clock, so everything is captured together.
  logic [11:0] rgb_q, rgb_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        fs_q, fs_d;

  always_comb begin
    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    fs_d    = 1'b0;
    if (!en) begin
      rgb_d   = '0;
      hsync_d = 1'b1;
      vsync_d = 1'b1;
    end else if (tick) begin
      rgb_d   = active ? colour : 12'h000;
      hsync_d = !hs_act;
      vsync_d = !vs_act;
      fs_d    = (hcnt_q == '0) && (vcnt_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      fs_q    <= fs_d;
    end
  end

  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;

endmodule
